// File: rtl/scan_sequencer.sv
// Instruction sequencer: queues 8-bit instructions in a 4-entry FIFO and plays each one
// into a control unit as 8 serial shifts, an update strobe, two run strobes and a result capture.
module scan_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic       data_in,
    output logic       shift,
    output logic       update,
    output logic       run,
    input  logic [4:0] z,
    output logic [4:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic [2:0] fifo_count
);

    typedef enum logic [2:0] {StIdle, StShift, StUpdate, StRun, StDone} state_e;

    state_e     state_q;
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic [7:0] working_q;
    logic [2:0] bit_cnt_q;
    logic       run_cnt_q;
    logic       push;
    logic       pop;

    // Ready depends on registered count only, so a full FIFO refuses even during a pop.
    assign instr_ready = (count_q < 3'd4);
    assign push        = instr_valid && instr_ready;
    assign pop         = (state_q == StIdle) && (count_q != 3'd0);
    assign fifo_count  = count_q;
    assign busy        = (state_q != StIdle) || (count_q != 3'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            working_q    <= 8'h00;
            bit_cnt_q    <= 3'd0;
            run_cnt_q    <= 1'b0;
            data_in      <= 1'b0;
            shift        <= 1'b0;
            update       <= 1'b0;
            run          <= 1'b0;
            result       <= 5'h00;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        working_q <= fifo_q[rd_ptr_q];
                        data_in   <= fifo_q[rd_ptr_q][0];
                        shift     <= 1'b1;
                        bit_cnt_q <= 3'd0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt_q == 3'd7) begin
                        shift   <= 1'b0;
                        data_in <= 1'b0;
                        update  <= 1'b1;
                        state_q <= StUpdate;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        data_in   <= working_q[bit_cnt_q + 3'd1];
                    end
                end
                StUpdate: begin
                    update    <= 1'b0;
                    run       <= 1'b1;
                    run_cnt_q <= 1'b0;
                    state_q   <= StRun;
                end
                StRun: begin
                    // Second run cycle covers the control unit's opcode decode lag.
                    if (run_cnt_q) begin
                        run     <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        run_cnt_q <= 1'b1;
                    end
                end
                StDone: begin
                    result       <= z;
                    result_valid <= (working_q[7:6] != 2'b00);
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: behavioural control unit on the scan chain, a timeline model of
// the queue and strobe schedule checked every cycle, and directed literal checks.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instr_in = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       data_in;
    logic       shift;
    logic       update;
    logic       run;
    logic [4:0] z;
    logic [4:0] result;
    logic       result_valid;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    scan_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .data_in     (data_in),
        .shift       (shift),
        .update      (update),
        .run         (run),
        .z           (z),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Instruction set of the control unit: 00 mem init, 01 ALU on mem[a], mem[a+1],
    // 10 read mem[a], 11 buffer the low five bits.
    function automatic logic [4:0] isa_z(input logic [7:0] ins, input logic [15:0] mem);
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] ma;
        logic [3:0] mb;
        a  = ins[1:0];
        b  = ins[1:0] + 2'd1;
        ma = mem[int'(a) * 4 +: 4];
        mb = mem[int'(b) * 4 +: 4];
        case (ins[7:6])
            2'b00: return {1'b0, ins[3:0]};
            2'b01: begin
                case (ins[5:4])
                    2'b00:   return {1'b0, ma} + {1'b0, mb};
                    2'b01:   return {1'b0, ma} - {1'b0, mb};
                    2'b10:   return {1'b0, ma & mb};
                    default: return {1'b0, ma | mb};
                endcase
            end
            2'b10:   return {1'b0, ma};
            default: return ins[4:0];
        endcase
    endfunction

    function automatic logic [15:0] mem_next(input logic [7:0] ins, input logic [15:0] mem);
        logic [15:0] m;
        m = mem;
        if (ins[7:6] == 2'b00) m[int'(ins[5:4]) * 4 +: 4] = ins[3:0];
        return m;
    endfunction

    // Control unit: shift chain, shadow latch, one-cycle decode lag, execute on second run.
    logic [7:0]  cu_sr = 8'h00;
    logic [7:0]  cu_shadow = 8'h00;
    logic [7:0]  cu_dec = 8'h00;
    logic        cu_lag = 1'b0;
    logic [15:0] cu_mem = 16'h0000;
    logic [4:0]  cu_z = 5'h00;

    always @(posedge clk) begin
        if (shift) cu_sr <= {data_in, cu_sr[7:1]};
        if (update) cu_shadow <= cu_sr;
        if (run) begin
            if (!cu_lag) begin
                cu_dec <= cu_shadow;
                cu_lag <= 1'b1;
            end else begin
                cu_lag <= 1'b0;
                cu_z   <= isa_z(cu_dec, cu_mem);
                cu_mem <= mem_next(cu_dec, cu_mem);
            end
        end
    end

    assign z = cu_z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an instruction popped in cycle P shifts in P+1..P+8, updates in P+9,
    // runs in P+10..P+11 and reports in P+13, when the next pop may happen.
    logic [7:0]  mq[$];
    logic [7:0]  cur = 8'h00;
    bit          has_cur = 1'b0;
    bit          model_on = 1'b0;
    int          cyc = 0;
    int          pcyc = 0;
    logic [4:0]  exp_res = 5'h00;
    logic [15:0] gold_mem = 16'h0000;
    int          n_shift = 0;
    int          n_upd = 0;
    int          n_run = 0;
    int          n_rv = 0;
    int          shift_streak = 0;

    initial begin
        int          cnt_prev;
        int          k;
        bit          active;
        logic        e_shift;
        logic        e_din;
        logic        e_rv;
        logic [14:0] exp_v;
        logic [14:0] act_v;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                has_cur  = 1'b0;
                exp_res  = 5'h00;
                model_on = 1'b1;
            end else if (model_on) begin
                cnt_prev = mq.size();
                k        = cyc - 1 - pcyc;
                active   = has_cur && k >= 1 && k <= 12;
                if (!active && cnt_prev > 0) begin
                    cur     = mq.pop_front();
                    pcyc    = cyc - 1;
                    has_cur = 1'b1;
                end
                if (instr_valid && cnt_prev < 4) mq.push_back(instr_in);
            end
            n_shift      += (shift === 1'b1) ? 1 : 0;
            n_upd        += (update === 1'b1) ? 1 : 0;
            n_run        += (run === 1'b1) ? 1 : 0;
            n_rv         += (result_valid === 1'b1) ? 1 : 0;
            shift_streak = (shift === 1'b1) ? shift_streak + 1 : 0;
            if (model_on) begin
                k       = cyc - pcyc;
                e_shift = has_cur && k >= 1 && k <= 8;
                e_din   = e_shift ? cur[k-1] : 1'b0;
                e_rv    = 1'b0;
                if (has_cur && k == 13) begin
                    exp_res  = isa_z(cur, gold_mem);
                    gold_mem = mem_next(cur, gold_mem);
                    e_rv     = (cur[7:6] != 2'b00);
                end
                exp_v = {mq.size() < 4, e_din, e_shift, has_cur && k == 9,
                         has_cur && (k == 10 || k == 11), exp_res, e_rv,
                         (has_cur && k >= 1 && k <= 12) || mq.size() != 0, 3'(mq.size())};
                act_v = {instr_ready, data_in, shift, update, run, result, result_valid,
                         busy, fifo_count};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL cycle %0d {rdy,din,sh,up,run,res,rv,busy,cnt}: got %b, want %b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    int peak = 0;
    bit saw_full_refuse = 1'b0;
    bit prev_refused_full = 1'b0;
    int trans_val = -1;

    task automatic observe();
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    // Holds instr_valid until a beat is accepted; returns one cycle after acceptance.
    task automatic push(input logic [7:0] ins);
        bit acc;
        instr_in    = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            observe();
            if (prev_refused_full && fifo_count != 3'd4) trans_val = int'(fifo_count);
            prev_refused_full = !instr_ready && fifo_count == 3'd4;
            if (prev_refused_full) saw_full_refuse = 1'b1;
            acc = instr_ready;
            @(negedge clk);
            #1;
            if (acc) return;
        end
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            observe();
            if (!busy) return;
            @(negedge clk);
            #1;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int s_shift;
        int s_upd;
        int s_run;
        int s_rv;
        bit found;

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_strobes", 32'({shift, update, run, data_in, result_valid}), 32'd0);

        // Memory initialise: mem[1] = 3, no result_valid.
        s_shift = n_shift; s_upd = n_upd; s_run = n_run; s_rv = n_rv;
        push(8'h13);
        instr_valid = 1'b0;
        wait_idle();
        check("init_shifted_bits", 32'(cu_shadow), 32'h13);
        check("init_mem1", 32'(cu_mem[7:4]), 32'h3);
        check("init_shift_cycles", 32'(n_shift - s_shift), 32'd8);
        check("init_update_pulses", 32'(n_upd - s_upd), 32'd1);
        check("init_run_pulses", 32'(n_run - s_run), 32'd2);
        check("init_no_rv", 32'(n_rv - s_rv), 32'd0);

        // Buffer.
        push(8'hD5);
        instr_valid = 1'b0;
        wait_idle();
        check("buffer_result", 32'(result), 32'h15);
        check("buffer_rv", 32'(result_valid), 32'd1);

        // Back-to-back: mem[1]=3, mem[2]=6, add.
        peak = 0;
        push(8'h13);
        push(8'h26);
        push(8'h41);
        instr_valid = 1'b0;
        wait_idle();
        check("add_result", 32'(result), 32'h09);
        check("add_peak_2_or_3", 32'(peak >= 2 && peak <= 3), 32'd1);

        // Six with valid held; the FIFO fills and a held beat is refused during the pop.
        s_rv = n_rv;
        saw_full_refuse = 1'b0;
        trans_val = -1;
        push(8'hC1);
        push(8'hD2);
        push(8'h35);
        push(8'h07);
        push(8'h43);
        push(8'hFE);
        instr_valid = 1'b0;
        wait_idle();
        check("six_last_result", 32'(result), 32'h1E);
        check("six_rv_pulses", 32'(n_rv - s_rv), 32'd4);
        check("six_full_refused", 32'(saw_full_refuse), 32'd1);
        check("six_full_4_to_3", 32'(trans_val), 32'd3);

        // Reset in the fourth shift cycle with two queued.
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        instr_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (shift_streak == 4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("rst_mid_found_shift4", 32'(found), 32'd1);
        check("rst_mid_queued", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_strobes", 32'({shift, update, run, data_in, result_valid}), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_ready", 32'(instr_ready), 32'd1);
        s_shift = n_shift; s_upd = n_upd; s_run = n_run; s_rv = n_rv;
        repeat (20) @(negedge clk);
        #1;
        check("rst_mid_no_strobes",
              32'((n_shift - s_shift) + (n_upd - s_upd) + (n_run - s_run) + (n_rv - s_rv)),
              32'd0);

        // Recovery: read mem[2].
        push(8'h86);
        instr_valid = 1'b0;
        wait_idle();
        check("read_result", 32'(result), 32'h06);
        check("read_rv", 32'(result_valid), 32'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
